// File: rtl/pipe_vr.sv
// Elastic valid/ready pipeline built from N full-throughput skid slices.
// Ready is registered per slice, so backpressure never forms a combinational path.
module pipe_vr #(
  parameter int N         = 1,
  parameter int W         = 32,
  parameter bit WithReset = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_empty
);

  logic [N:0]        vld;
  logic [N:0]        rdy;
  logic [N:0][W-1:0] dat;
  logic [N-1:0]      busy;

  assign vld[0]  = i_valid;
  assign dat[0]  = i_data;
  assign o_ready = rdy[0];
  assign rdy[N]  = i_ready;
  assign o_valid = vld[N];
  assign o_data  = dat[N];
  assign o_empty = ~|busy;

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic         m_valid_q, m_valid_d;
    logic         s_valid_q, s_valid_d;
    logic [W-1:0] m_data_q, m_data_d;
    logic [W-1:0] s_data_q, s_data_d;
    logic         accept;
    logic         free;

    assign accept = vld[k] & ~s_valid_q;
    assign free   = rdy[k+1] | ~m_valid_q;

    always_comb begin
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      m_data_d  = m_data_q;
      s_data_d  = s_data_q;
      if (free) begin
        if (s_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data_q;
          s_valid_d = 1'b0;
        end else begin
          m_valid_d = accept;
          if (accept) m_data_d = dat[k];
        end
      end else if (accept) begin
        // main is stalled: park the beat in the skid
        s_valid_d = 1'b1;
        s_data_d  = dat[k];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        m_valid_q <= 1'b0;
        s_valid_q <= 1'b0;
      end else begin
        m_valid_q <= m_valid_d;
        s_valid_q <= s_valid_d;
      end
    end

    if (WithReset) begin : g_rst
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          m_data_q <= '0;
          s_data_q <= '0;
        end else begin
          m_data_q <= m_data_d;
          s_data_q <= s_data_d;
        end
      end
    end else begin : g_nrst
      always_ff @(posedge clk) begin
        m_data_q <= m_data_d;
        s_data_q <= s_data_d;
      end
    end

    assign rdy[k]   = ~s_valid_q;
    assign vld[k+1] = m_valid_q;
    assign dat[k+1] = m_data_q;
    assign busy[k]  = m_valid_q | s_valid_q;
  end

endmodule

// File: tb/tb_pipe_vr.sv
// Bench for pipe_vr: three instances (N=2, N=3 with payload reset, N=4)
// checked against latency/capacity rules and a FIFO scoreboard.
module tb_pipe_vr;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iv   [3];
  logic       ir   [3];
  logic       ov   [3];
  logic       ordy [3];
  logic       oe   [3];
  logic [7:0] id   [3];
  logic [7:0] od   [3];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_vr #(.N(2), .W(8), .WithReset(1'b0)) u_n2 (
    .clk(clk), .reset(reset),
    .i_valid(iv[0]), .o_ready(ordy[0]), .i_data(id[0]),
    .o_valid(ov[0]), .i_ready(ir[0]), .o_data(od[0]),
    .o_empty(oe[0])
  );

  pipe_vr #(.N(3), .W(8), .WithReset(1'b1)) u_n3 (
    .clk(clk), .reset(reset),
    .i_valid(iv[1]), .o_ready(ordy[1]), .i_data(id[1]),
    .o_valid(ov[1]), .i_ready(ir[1]), .o_data(od[1]),
    .o_empty(oe[1])
  );

  pipe_vr #(.N(4), .W(8), .WithReset(1'b0)) u_n4 (
    .clk(clk), .reset(reset),
    .i_valid(iv[2]), .o_ready(ordy[2]), .i_data(id[2]),
    .o_valid(ov[2]), .i_ready(ir[2]), .o_data(od[2]),
    .o_empty(oe[2])
  );

  task automatic test_reset;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0;
      ir[d] = 1'b1;
      id[d] = 8'h00;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ovalid dut%0d: got %b want 0", d, ov[d]);
      end
      checks++;
      if (ordy[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_oready dut%0d: got %b want 1", d, ordy[d]);
      end
      checks++;
      if (oe[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_oempty dut%0d: got %b want 1", d, oe[d]);
      end
    end
    checks++;
    if (od[1] !== 8'h00) begin
      errors++;
      $display("FAIL reset_odata: got %h want 00", od[1]);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ov[1] !== 1'b0 || oe[1] !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: ov=%b oe=%b want 0/1", ov[1], oe[1]);
    end
  endtask

  task automatic test_single;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      iv[1] = (j == 0);
      id[1] = (j == 0) ? 8'hA5 : 8'h00;
      ir[1] = 1'b1;
      #1;
      checks++;
      if (ov[1] !== (j == 3)) begin
        errors++;
        $display("FAIL single_valid cyc%0d: got %b want %b", j, ov[1], j == 3);
      end
      if (j == 3) begin
        checks++;
        if (od[1] !== 8'hA5) begin
          errors++;
          $display("FAIL single_data: got %h want a5", od[1]);
        end
      end
    end
    checks++;
    if (oe[1] !== 1'b1) begin
      errors++;
      $display("FAIL single_empty: got %b want 1", oe[1]);
    end
  endtask

  task automatic test_throughput;
    logic want;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      iv[0] = (j < 16);
      id[0] = 8'(j + 1);
      ir[0] = 1'b1;
      #1;
      if (j < 16) begin
        checks++;
        if (ordy[0] !== 1'b1) begin
          errors++;
          $display("FAIL thru_ready cyc%0d: got %b want 1", j, ordy[0]);
        end
      end
      want = (j >= 2 && j < 18);
      checks++;
      if (ov[0] !== want) begin
        errors++;
        $display("FAIL thru_valid cyc%0d: got %b want %b", j, ov[0], want);
      end
      if (want) begin
        checks++;
        if (od[0] !== 8'(j - 1)) begin
          errors++;
          $display("FAIL thru_data cyc%0d: got %h want %h", j, od[0], 8'(j - 1));
        end
      end
    end
  endtask

  task automatic test_fill_stall;
    int acc;
    acc = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      iv[0] = 1'b1;
      ir[0] = 1'b0;
      id[0] = 8'(acc + 1);
      #1;
      if (ordy[0] === 1'b1) acc++;
    end
    checks++;
    if (acc != 4) begin
      errors++;
      $display("FAIL fill_count: got %0d want 4", acc);
    end
    checks++;
    if (ordy[0] !== 1'b0 || oe[0] !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: ready=%b empty=%b want 0/0", ordy[0], oe[0]);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      iv[0] = 1'b0;
      ir[0] = 1'b1;
      #1;
      checks++;
      if (ov[0] !== (k < 4)) begin
        errors++;
        $display("FAIL drain_valid cyc%0d: got %b want %b", k, ov[0], k < 4);
      end
      if (k < 4) begin
        checks++;
        if (od[0] !== 8'(k + 1)) begin
          errors++;
          $display("FAIL drain_data cyc%0d: got %h want %h", k, od[0], 8'(k + 1));
        end
      end
    end
    checks++;
    if (oe[0] !== 1'b1 || ordy[0] !== 1'b1) begin
      errors++;
      $display("FAIL drain_idle: empty=%b ready=%b want 1/1", oe[0], ordy[0]);
    end
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] exp;
    logic       rb, vb;
    int         guard;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      rb = ordy[2];
      vb = ov[2];
      checks++;
      if (oe[2] !== (q.size() == 0)) begin
        errors++;
        $display("FAIL rnd_empty cyc%0d: got %b want %b", c, oe[2], q.size() == 0);
      end
      iv[2] = 1'($urandom_range(0, 1));
      ir[2] = 1'($urandom_range(0, 1));
      id[2] = 8'($urandom);
      #1;
      checks++;
      if (ordy[2] !== rb || ov[2] !== vb) begin
        errors++;
        $display("FAIL rnd_comb cyc%0d: ready %b->%b valid %b->%b", c, rb, ordy[2], vb, ov[2]);
      end
      if (ov[2] === 1'b1 && ir[2] === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra cyc%0d: got %h want nothing", c, od[2]);
        end else begin
          exp = q.pop_front();
          if (od[2] !== exp) begin
            errors++;
            $display("FAIL rnd_data cyc%0d: got %h want %h", c, od[2], exp);
          end
        end
      end
      if (iv[2] === 1'b1 && ordy[2] === 1'b1) q.push_back(id[2]);
      checks++;
      if (q.size() > 8) begin
        errors++;
        $display("FAIL rnd_occ cyc%0d: got %0d want <=8", c, q.size());
      end
    end
    guard = 0;
    while (q.size() != 0 && guard < 40) begin
      @(negedge clk);
      iv[2] = 1'b0;
      ir[2] = 1'b1;
      #1;
      if (ov[2] === 1'b1) begin
        exp = q.pop_front();
        checks++;
        if (od[2] !== exp) begin
          errors++;
          $display("FAIL rnd_drain: got %h want %h", od[2], exp);
        end
      end
      guard++;
    end
    @(negedge clk);
    checks++;
    if (q.size() != 0 || oe[2] !== 1'b1) begin
      errors++;
      $display("FAIL rnd_final: left=%0d empty=%b want 0/1", q.size(), oe[2]);
    end
  endtask

  task automatic test_reset_mid;
    int acc;
    acc = 0;
    for (int j = 0; j < 10 && acc < 5; j++) begin
      @(negedge clk);
      iv[1] = 1'b1;
      ir[1] = 1'b0;
      id[1] = 8'(acc + 16);
      #1;
      if (ordy[1] === 1'b1) acc++;
    end
    @(negedge clk);
    iv[1] = 1'b0;
    #1;
    checks++;
    if (acc != 5 || oe[1] !== 1'b0 || ov[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_held: acc=%0d empty=%b valid=%b want 5/0/1", acc, oe[1], ov[1]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ov[1] !== 1'b0 || oe[1] !== 1'b1 || ordy[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: valid=%b empty=%b ready=%b want 0/1/1", ov[1], oe[1], ordy[1]);
    end
    checks++;
    if (od[1] !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_data: got %h want 00", od[1]);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      iv[1] = (j == 0);
      id[1] = 8'h3C;
      ir[1] = 1'b1;
      #1;
      checks++;
      if (ov[1] !== (j == 3)) begin
        errors++;
        $display("FAIL mid_valid cyc%0d: got %b want %b", j, ov[1], j == 3);
      end
      if (j == 3) begin
        checks++;
        if (od[1] !== 8'h3C) begin
          errors++;
          $display("FAIL mid_data: got %h want 3c", od[1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_throughput();
    test_fill_stall();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
